// File: rtl/if_fetch_btb_pkg.sv
// Shared definitions for the fetch stage and its branch target buffer:
// counter encodings, default reset PC and index/tag width helpers.
package if_fetch_btb_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;
    localparam int          DEF_BTB_IDX_BITS = 4;

    // Word-aligned PC: two low bits dropped, index bits taken, tag is the rest.
    function automatic int idx_bits_w(input int idx_bits);
        return idx_bits;
    endfunction

    function automatic int tag_bits_w(input int idx_bits);
        return 30 - idx_bits;
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != ST) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != SNT) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/if_fetch_btb_table.sv
// Direct-mapped BTB storage: combinational read port and a synchronous
// update port that trains the 2-bit counter or allocates on a taken miss.
module btb_table
    import if_fetch_btb_pkg::*;
#(
    parameter int IDX_BITS = DEF_BTB_IDX_BITS,
    parameter int TAG_W    = tag_bits_w(DEF_BTB_IDX_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_target,
    output logic [1:0]          rd_ctr,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic [TAG_W-1:0]    upd_tag,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    // Reads see registered contents only, so a same-cycle update is invisible.
    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid) begin
            if (valid_q[upd_idx] && tag_q[upd_idx] == upd_tag) begin
                ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken);
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: rtl/if_fetch_btb.sv
// Fetch stage: PC register, next-PC selection (redirect, stall, BTB
// prediction, sequential) and the valid flag handed to IF/ID.
module if_fetch_btb
    import if_fetch_btb_pkg::*;
#(
    parameter int          BTB_IDX_BITS   = DEF_BTB_IDX_BITS,
    parameter int          IMEM_ADDR_BITS = 10,
    parameter logic [31:0] RESET_PC       = DEF_RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Enable,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    input  logic                      upd_valid,
    input  logic [31:0]               upd_pc,
    input  logic                      upd_taken,
    input  logic [31:0]               upd_target,
    output logic [IMEM_ADDR_BITS-1:0] imem_addr,
    input  logic [31:0]               imem_data,
    output logic [31:0]               PC_out,
    output logic [31:0]               IR_out,
    output logic                      Effective_out,
    output logic                      pre_jmp_out,
    output logic                      hit_out
);

    localparam int IDX_W = idx_bits_w(BTB_IDX_BITS);
    localparam int TAG_W = tag_bits_w(BTB_IDX_BITS);

    logic [31:0]      pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_target;
    logic [1:0]       rd_ctr;
    logic [1:0]       unused_low_bits;

    assign unused_low_bits = pc_q[1:0] ^ upd_pc[1:0];

    btb_table #(
        .IDX_BITS (IDX_W),
        .TAG_W    (TAG_W)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (pc_q[IDX_W+1:2]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_ctr     (rd_ctr),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_pc[IDX_W+1:2]),
        .upd_tag    (upd_pc[31:IDX_W+2]),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    assign hit_out       = rd_valid && (rd_tag == pc_q[31:IDX_W+2]);
    assign pre_jmp_out   = hit_out && rd_ctr[1];
    assign PC_out        = pc_q;
    assign IR_out        = imem_data;
    assign imem_addr     = pc_q[IMEM_ADDR_BITS+1:2];
    assign Effective_out = valid_q;

    // A redirect from EX must win over a stall, otherwise a stalled front end
    // would keep fetching down the wrong path.
    always_comb begin
        pc_d    = pc_q + 32'd4;
        valid_d = 1'b1;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (Enable) begin
            pc_d = pc_q;
        end else if (pre_jmp_out) begin
            pc_d = rd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_btb.sv
// Self-checking bench for if_fetch_btb: table-driven scenarios, expected
// fetch outputs pushed to a queue per cycle and compared after each edge.
module tb_if_fetch_btb;

    logic        clk;
    logic        rst;
    logic        Enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] PC_out;
    logic [31:0] IR_out;
    logic        Effective_out;
    logic        pre_jmp_out;
    logic        hit_out;

    int checks   = 0;
    int failures = 0;

    logic [66:0] exp_q[$];
    logic [66:0] got_w;
    logic [66:0] exp_w;

    typedef struct {
        logic        rst;
        logic        en;
        logic        red;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] epc;
        logic        eff;
        logic        hit;
        logic        pre;
    } step_t;

    if_fetch_btb dut (
        .clk           (clk),
        .rst           (rst),
        .Enable        (Enable),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .PC_out        (PC_out),
        .IR_out        (IR_out),
        .Effective_out (Effective_out),
        .pre_jmp_out   (pre_jmp_out),
        .hit_out       (hit_out)
    );

    // ---------------- clock / reset / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ {22'b0, pc[11:2]};
    endfunction

    assign imem_data = 32'hC0DE_0000 ^ {22'b0, imem_addr};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input step_t s);
        rst         = s.rst;
        Enable      = s.en;
        redirect    = s.red;
        redirect_pc = s.rpc;
        upd_valid   = s.uv;
        upd_pc      = s.upc;
        upd_taken   = s.ut;
        upd_target  = s.utgt;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic eff, input logic hit, input logic pre);
        exp_q.push_back({pc, rom(pc), eff, hit, pre});
    endtask

    function automatic step_t mk(input logic r, input logic en, input logic red, input logic [31:0] rpc,
                                 input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                                 input logic [31:0] epc, input logic eff, input logic hit, input logic pre);
        step_t s;
        s.rst = r; s.en = en; s.red = red; s.rpc = rpc;
        s.uv = uv; s.upc = upc; s.ut = ut; s.utgt = utgt;
        s.epc = epc; s.eff = eff; s.hit = hit; s.pre = pre;
        return s;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step_t st[$];
        st.push_back(mk(1,0,0,0, 0,0,0,0, 32'h0, 0,0,0));
        st.push_back(mk(0,0,0,0, 0,0,0,0, 32'h4, 1,0,0));
        st.push_back(mk(0,0,0,0, 0,0,0,0, 32'h8, 1,0,0));
        st.push_back(mk(0,0,0,0, 0,0,0,0, 32'hC, 1,0,0));
        foreach (st[i]) begin
            apply(st[i]);
            push_exp(st[i].epc, st[i].eff, st[i].hit, st[i].pre);
            tick();
            got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL reset[%0d] got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                         i, got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
            end
        end
    endtask

    task automatic test_taken_alloc();
        step_t st[$];
        st.push_back(mk(0,0,0,0, 1,32'h10,1,32'h40, 32'h10, 1,1,1));
        st.push_back(mk(0,0,0,0, 0,0,0,0,           32'h40, 1,0,0));
        foreach (st[i]) begin
            apply(st[i]);
            push_exp(st[i].epc, st[i].eff, st[i].hit, st[i].pre);
            tick();
            got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL taken_alloc[%0d] got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                         i, got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
            end
        end
    endtask

    // 10 -> 01 -> 00 -> 00 (saturate), then taken -> 01: still predicts not taken.
    task automatic test_not_taken();
        step_t st[$];
        st.push_back(mk(0,1,0,0,     1,32'h10,0,0,       32'h40, 1,0,0));
        st.push_back(mk(0,1,0,0,     1,32'h10,0,0,       32'h40, 1,0,0));
        st.push_back(mk(0,1,0,0,     1,32'h10,0,0,       32'h40, 1,0,0));
        st.push_back(mk(0,1,0,0,     1,32'h10,1,32'h44,  32'h40, 1,0,0));
        st.push_back(mk(0,1,1,32'h10, 0,0,0,0,           32'h10, 1,1,0));
        st.push_back(mk(0,0,0,0,     0,0,0,0,            32'h14, 1,0,0));
        foreach (st[i]) begin
            apply(st[i]);
            push_exp(st[i].epc, st[i].eff, st[i].hit, st[i].pre);
            tick();
            got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL not_taken[%0d] got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                         i, got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
            end
        end
    endtask

    task automatic test_redirect_stall();
        step_t st[$];
        st.push_back(mk(0,1,1,32'h80, 0,0,0,0, 32'h80, 1,0,0));
        st.push_back(mk(0,1,0,0,      0,0,0,0, 32'h80, 1,0,0));
        st.push_back(mk(0,1,0,0,      0,0,0,0, 32'h80, 1,0,0));
        st.push_back(mk(0,1,0,0,      0,0,0,0, 32'h80, 1,0,0));
        st.push_back(mk(0,0,0,0,      0,0,0,0, 32'h84, 1,0,0));
        foreach (st[i]) begin
            apply(st[i]);
            push_exp(st[i].epc, st[i].eff, st[i].hit, st[i].pre);
            tick();
            got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL redirect_stall[%0d] got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                         i, got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
            end
        end
    endtask

    // 0x50 shares index 4 with 0x10; the last step proves the new counter was 10.
    task automatic test_alias();
        step_t st[$];
        st.push_back(mk(0,0,1,32'h10, 1,32'h50,1,32'h200, 32'h10,  1,0,0));
        st.push_back(mk(0,0,1,32'h50, 0,0,0,0,            32'h50,  1,1,1));
        st.push_back(mk(0,0,0,0,      0,0,0,0,            32'h200, 1,0,0));
        st.push_back(mk(0,0,1,32'h50, 1,32'h50,0,0,       32'h50,  1,1,0));
        foreach (st[i]) begin
            apply(st[i]);
            push_exp(st[i].epc, st[i].eff, st[i].hit, st[i].pre);
            tick();
            got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL alias[%0d] got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                         i, got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
            end
        end
    endtask

    // Lookup at 0x50 (ctr 01) while a taken update to the same entry is pending.
    task automatic test_same_cycle();
        apply(mk(0,0,0,0, 1,32'h50,1,32'h300, 0,0,0,0));
        #1;
        push_exp(32'h50, 1, 1, 0);
        got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
        exp_w = exp_q.pop_front();
        checks++;
        if (got_w !== exp_w) begin
            failures++;
            $display("FAIL same_cycle_lookup got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                     got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
        end
        push_exp(32'h54, 1, 0, 0);
        tick();
        got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
        exp_w = exp_q.pop_front();
        checks++;
        if (got_w !== exp_w) begin
            failures++;
            $display("FAIL same_cycle_next got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                     got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
        end
    endtask

    // Counter at 10: four taken saturate at 11; one not-taken gives 10 (still taken).
    task automatic test_saturation();
        step_t st[$];
        for (int k = 0; k < 4; k++) begin
            st.push_back(mk(0,1,0,0, 1,32'h50,1,32'h300, 32'h54, 1,0,0));
        end
        st.push_back(mk(0,1,1,32'h50, 1,32'h50,0,0, 32'h50,  1,1,1));
        st.push_back(mk(0,0,0,0,      0,0,0,0,      32'h300, 1,0,0));
        foreach (st[i]) begin
            apply(st[i]);
            push_exp(st[i].epc, st[i].eff, st[i].hit, st[i].pre);
            tick();
            got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL saturation[%0d] got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                         i, got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
            end
        end
    endtask

    task automatic test_reset_with_update();
        step_t st[$];
        st.push_back(mk(1,0,0,0,      1,32'h0,1,32'h100, 32'h0,  0,0,0));
        st.push_back(mk(0,0,0,0,      0,0,0,0,           32'h4,  1,0,0));
        st.push_back(mk(0,0,1,32'h50, 0,0,0,0,           32'h50, 1,0,0));
        st.push_back(mk(0,0,1,32'h0,  0,0,0,0,           32'h0,  1,0,0));
        st.push_back(mk(0,0,1,32'h10, 0,0,0,0,           32'h10, 1,0,0));
        st.push_back(mk(0,0,0,0,      0,0,0,0,           32'h14, 1,0,0));
        foreach (st[i]) begin
            apply(st[i]);
            push_exp(st[i].epc, st[i].eff, st[i].hit, st[i].pre);
            tick();
            got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL reset_update[%0d] got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                         i, got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
            end
        end
    endtask

    task automatic test_wrap();
        step_t st[$];
        st.push_back(mk(0,0,1,32'hFFFF_FFFC, 0,0,0,0, 32'hFFFF_FFFC, 1,0,0));
        st.push_back(mk(0,0,0,0,             0,0,0,0, 32'h0,         1,0,0));
        st.push_back(mk(0,0,0,0,             0,0,0,0, 32'h4,         1,0,0));
        foreach (st[i]) begin
            apply(st[i]);
            push_exp(st[i].epc, st[i].eff, st[i].hit, st[i].pre);
            tick();
            got_w = {PC_out, IR_out, Effective_out, hit_out, pre_jmp_out};
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL wrap[%0d] got pc=%h ir=%h e/h/p=%b expected pc=%h ir=%h e/h/p=%b",
                         i, got_w[66:35], got_w[34:3], got_w[2:0], exp_w[66:35], exp_w[34:3], exp_w[2:0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        apply(mk(1,0,0,0, 0,0,0,0, 0,0,0,0));
        repeat (2) tick();
        test_reset();
        test_taken_alloc();
        test_not_taken();
        test_redirect_stall();
        test_alias();
        test_same_cycle();
        test_saturation();
        test_reset_with_update();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d leftover entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
